noc_edge_mux: RTL and testbench
===============================

NOC_EDGE_MUX -- requirements
Module: noc_edge_mux

Interface
REQ-001 Parameter N_CH, default 2, number of injector channels sharing one boundary Hermes port, legal range 2..8.
REQ-002 Parameter FLIT_SIZE, default 32, flit width in bits.
REQ-003 Parameter MAX_PAYLOAD, default 65535, largest legal payload flit count; a larger size flit is clamped to MAX_PAYLOAD.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 release_i  input  1  high enables new grants; low blocks new grants only.
REQ-007 src_rx_i  input  N_CH  per-channel flit valid.
REQ-008 src_data_i  input  N_CH x FLIT_SIZE  per-channel flit.
REQ-009 src_credit_o  output  N_CH  per-channel credit (ready).
REQ-010 noc_tx_o  output  1  flit valid towards router port.
REQ-011 noc_data_o  output  FLIT_SIZE  flit towards router port.
REQ-012 noc_credit_i  input  1  router port credit.
REQ-013 grant_o  output  N_CH  one-hot owner of the port; all zero when idle.
REQ-014 busy_o  output  1  high while a packet is in flight.

Function
REQ-015 A flit transfers on a cycle where noc_tx_o and noc_credit_i are both high.
REQ-016 Packet format: header flit, then size flit S, then S payload flits.
REQ-017 FSM states: IDLE, HEADER, SIZE, PAYLOAD.
REQ-018 IDLE: when release_i=1 and any src_rx_i bit is high, the block registers a round-robin grant, starting search at (last_grant+1) mod N_CH, and moves to HEADER.
REQ-019 HEADER -> SIZE on a header transfer; SIZE -> PAYLOAD on a size transfer.
REQ-020 On a size transfer the block loads the payload counter with min(S, MAX_PAYLOAD); if S=0, it moves from SIZE directly to IDLE.
REQ-021 PAYLOAD: the counter decrements on each transfer; the transfer with counter=1 returns the FSM to IDLE and clears the grant.
REQ-022 Outside IDLE: noc_tx_o=src_rx_i[g], noc_data_o=src_data_i[g], src_credit_o[g]=noc_credit_i; all other src_credit_o bits are 0. This path is combinational, zero latency.
REQ-023 In IDLE, noc_tx_o=0 and src_credit_o=0; exactly one idle arbitration cycle separates consecutive packets.
REQ-024 When release_i falls mid-packet, the packet completes; no new grant is issued until release_i=1.
REQ-025 If the granted source deasserts src_rx_i mid-packet, the block holds the grant and inserts no other channel's flits (no interleaving).
REQ-026 last_grant updates only when a grant is issued; a single requesting channel is re-granted after its bubble cycle.
REQ-027 Counter width is clog2(MAX_PAYLOAD+1); it never wraps below 0.

Reset
REQ-028 While rst_i=1, on the clock edge: FSM=IDLE, counter=0, grant_o=0, last_grant=N_CH-1 (so channel 0 wins first), busy_o=0.
REQ-029 While rst_i=1, noc_tx_o=0 and src_credit_o=0; a packet cut by reset is dropped, with no recovery.

Configuration
REQ-030 Macro NOC_EDGE_MUX_STATS_EN, when defined, adds output pkt_count_o (N_CH x 16 bits): per-channel completed-packet counters, incremented on the final flit, wrapping at 16'hFFFF -> 0, and cleared by rst_i.
REQ-031 Without NOC_EDGE_MUX_STATS_EN, the port and its counters are absent and all other behaviour is identical.

Structure
REQ-032 A shared package NocEdgeMuxPkg holds the FSM state enum and constants HDR_IDX=0 and SIZE_IDX=1.
REQ-033 Round-robin selection is a separate sub-module, rr_arbiter (N_CH requests, last-grant input, one-hot grant output), and is purely combinational.

Verification
REQ-034 Reset, then ch0 sends header/size=3/3 payloads with credit held high -> 5 transfers in 5 consecutive cycles, busy_o falls after the 5th, grant_o=0.
REQ-035 ch0 and ch1 request continuously with size=2 -> grants alternate ch0, ch1, ch0, and no flit of one packet appears inside another.
REQ-036 size=0 packet on ch1 -> exactly 2 transfers, then IDLE.
REQ-037 noc_credit_i low for 4 cycles mid-payload -> noc_tx_o held, data stable, counter unchanged, and the packet resumes.
REQ-038 release_i dropped after the header of ch0 (size=4) -> all 6 flits complete; ch1 stays ungranted until release_i=1.
REQ-039 rst_i asserted during PAYLOAD -> next cycle all outputs are 0; after release, with both channels requesting, ch0 wins.

Source files
------------

// File: rtl/noc_edge_mux_pkg.sv
// Shared types and constants for the NoC edge multiplexer.
package NocEdgeMuxPkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_SIZE    = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_e;

  // Flit positions within a packet: header first, then the payload size.
  localparam int unsigned HDR_IDX  = 0;
  localparam int unsigned SIZE_IDX = 1;

endpackage

// File: rtl/noc_edge_mux_rr_arbiter.sv
// Combinational round-robin arbiter: searches from (last grant + 1) mod N_CH
// and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N_CH = 2,
  parameter int GW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [GW-1:0]   i_last,
  output logic [N_CH-1:0] o_grant,
  output logic [GW-1:0]   o_grant_idx
);

  logic          w_found;
  logic [GW-1:0] w_idx;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int i = 1; i <= N_CH; i++) begin
      w_idx = GW'((int'(i_last) + i) % N_CH);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_edge_mux.sv
// N_CH injector channels share one boundary Hermes port, one packet at a time.
// Optional per-channel packet counters are enabled by NOC_EDGE_MUX_STATS_EN.
module noc_edge_mux
  import NocEdgeMuxPkg::*;
#(
  parameter int N_CH        = 2,
  parameter int FLIT_SIZE   = 32,
  parameter int MAX_PAYLOAD = 65535
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           release_i,
  input  logic [N_CH-1:0]                src_rx_i,
  input  logic [N_CH-1:0][FLIT_SIZE-1:0] src_data_i,
  output logic [N_CH-1:0]                src_credit_o,
  output logic                           noc_tx_o,
  output logic [FLIT_SIZE-1:0]           noc_data_o,
  input  logic                           noc_credit_i,
  output logic [N_CH-1:0]                grant_o,
  output logic                           busy_o
`ifdef NOC_EDGE_MUX_STATS_EN
  ,
  output logic [N_CH-1:0][15:0]          pkt_count_o
`endif
);

  localparam int          GW       = $clog2(N_CH);
  localparam int          CW       = $clog2(MAX_PAYLOAD + 1);
  localparam logic [63:0] MAX_P64  = 64'(MAX_PAYLOAD);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N_CH-1:0] r_grant;
  logic [GW-1:0]   r_gidx;
  logic [GW-1:0]   r_last;
  logic            r_busy;

  logic [N_CH-1:0] w_arb_grant;
  logic [GW-1:0]   w_arb_idx;
  logic            w_xfer;
  logic [63:0]     w_size_ext;
  logic [CW-1:0]   w_size_clamp;
  logic            w_pkt_done;

  rr_arbiter #(
    .N_CH (N_CH),
    .GW   (GW)
  ) u_arb (
    .i_req       (src_rx_i),
    .i_last      (r_last),
    .o_grant     (w_arb_grant),
    .o_grant_idx (w_arb_idx)
  );

  // Zero-latency path from the owning channel; silenced in IDLE and in reset.
  always_comb begin
    noc_tx_o     = 1'b0;
    noc_data_o   = '0;
    src_credit_o = '0;
    if (r_state != ST_IDLE && !rst_i) begin
      noc_tx_o             = src_rx_i[r_gidx];
      noc_data_o           = src_data_i[r_gidx];
      src_credit_o[r_gidx] = noc_credit_i;
    end
  end

  assign w_xfer       = noc_tx_o & noc_credit_i;
  assign w_size_ext   = 64'(noc_data_o);
  assign w_size_clamp = (w_size_ext > MAX_P64) ? CW'(MAX_PAYLOAD) : CW'(w_size_ext);
  assign w_pkt_done   = w_xfer &&
                        ((r_state == ST_SIZE    && w_size_clamp == '0) ||
                         (r_state == ST_PAYLOAD && r_cnt <= CW'(1)));

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= GW'(N_CH - 1);
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (release_i && |src_rx_i) begin
            r_state <= ST_HEADER;
            r_grant <= w_arb_grant;
            r_gidx  <= w_arb_idx;
            r_last  <= w_arb_idx;
            r_busy  <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (w_xfer) r_state <= ST_SIZE;
        end
        ST_SIZE: begin
          if (w_xfer) begin
            r_cnt <= w_size_clamp;
            if (w_pkt_done) begin
              r_state <= ST_IDLE;
              r_grant <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_xfer) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            if (w_pkt_done) begin
              r_state <= ST_IDLE;
              r_grant <= '0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_o = r_grant;
  assign busy_o  = r_busy;

`ifdef NOC_EDGE_MUX_STATS_EN
  logic [N_CH-1:0][15:0] r_pkt_count;

  // Counters wrap naturally at 16'hFFFF; they are architectural state, so reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pkt_count <= '0;
    end else if (w_pkt_done) begin
      r_pkt_count[r_gidx] <= r_pkt_count[r_gidx] + 16'd1;
    end
  end

  assign pkt_count_o = r_pkt_count;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_noc_edge_mux.sv
// Scoreboard bench for noc_edge_mux: per-channel source queues feed the DUT,
// expected transfers are queued at load time and checked by a monitor.
module tb_noc_edge_mux;
  import NocEdgeMuxPkg::*;

  localparam int N_CH = 2;
  localparam int FW   = 32;
  localparam int MAXP = 6;

  logic                    clk = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    release_i = 1'b1;
  logic [N_CH-1:0]         src_rx_i = '0;
  logic [N_CH-1:0][FW-1:0] src_data_i = '0;
  logic [N_CH-1:0]         src_credit_o;
  logic                    noc_tx_o;
  logic [FW-1:0]           noc_data_o;
  logic                    noc_credit_i = 1'b1;
  logic [N_CH-1:0]         grant_o;
  logic                    busy_o;

  always #5 clk = ~clk;

  noc_edge_mux #(
    .N_CH        (N_CH),
    .FLIT_SIZE   (FW),
    .MAX_PAYLOAD (MAXP)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .release_i    (release_i),
    .src_rx_i     (src_rx_i),
    .src_data_i   (src_data_i),
    .src_credit_o (src_credit_o),
    .noc_tx_o     (noc_tx_o),
    .noc_data_o   (noc_data_o),
    .noc_credit_i (noc_credit_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    int          ch;
    logic [FW-1:0] data;
    bit          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [FW-1:0] q0[$];
  logic [FW-1:0] q1[$];
  logic [N_CH-1:0] hold = '0;

  int n_total = 0;
  int n_bad   = 0;
  int xfer_count = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  bit chk_bubble = 1'b0;
  bit prev_last  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_total++;
    n_bad++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  // Queue one packet on a source and its expected transfers on the scoreboard.
  // n_pay is the hand-computed number of payload flits the port should carry.
  task automatic load_pkt(input int ch, input logic [FW-1:0] hdr,
                          input logic [FW-1:0] size_f, input int n_pay);
    int nfl;
    logic [FW-1:0] f;
    exp_t e;
    nfl = n_pay + 2;
    for (int k = 0; k < nfl; k++) begin
      if (k == HDR_IDX)       f = hdr;
      else if (k == SIZE_IDX) f = size_f;
      else                    f = hdr + FW'(k - 1);
      if (ch == 0) q0.push_back(f);
      else         q1.push_back(f);
      e.ch   = ch;
      e.data = f;
      e.last = (k == nfl - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input string name, input int n, input int max_cyc);
    int c;
    c = 0;
    while (xfer_count < n && c < max_cyc) begin
      step();
      c++;
    end
    if (xfer_count < n) fail_now(name, "timeout waiting for transfers");
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int c;
    c = 0;
    while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0 || busy_o) && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() > 0 || busy_o) fail_now(name, "timeout, packet did not complete");
    @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  // Source model: a flit leaves its queue when it was offered and credited.
  initial begin : driver
    logic [N_CH-1:0] acc;
    forever begin
      @(negedge clk);
      acc = src_rx_i & src_credit_o;
      @(posedge clk);
      #1;
      if (acc[0] && q0.size() > 0) q0.delete(0);
      if (acc[1] && q1.size() > 0) q1.delete(0);
      src_rx_i[0]   = (q0.size() > 0) && !hold[0];
      src_data_i[0] = (q0.size() > 0) ? q0[0] : '0;
      src_rx_i[1]   = (q1.size() > 0) && !hold[1];
      src_data_i[1] = (q1.size() > 0) ? q1[0] : '0;
    end
  end

  // Monitor: compare every port transfer against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (chk_bubble) begin
      check("busy_after_xfer", busy_o, !prev_last);
      if (prev_last) begin
        check("bubble_grant", grant_o, 0);
        check("bubble_tx", noc_tx_o, 0);
      end
      chk_bubble = 1'b0;
    end
    if (!rst_i && noc_tx_o && noc_credit_i) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_xfer", $sformatf("data %0h with empty scoreboard", noc_data_o));
      end else begin
        e = exp_q.pop_front();
        check("xfer_data", noc_data_o, e.data);
        check("xfer_grant", grant_o, 64'(1) << e.ch);
        check("xfer_credit", src_credit_o, 64'(1) << e.ch);
        prev_last  = e.last;
        chk_bubble = 1'b1;
      end
      if (xfer_count == 0) first_cyc = cyc;
      last_cyc = cyc;
      xfer_count++;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [FW-1:0] held;
    int c;

    // Reset state
    @(negedge clk);
    check("rst_tx", noc_tx_o, 0);
    check("rst_credit", src_credit_o, 0);
    step();
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;

    // ch0 header/size=3/3 payloads: 5 transfers on 5 consecutive cycles
    xfer_count = 0;
    load_pkt(0, 32'hA000_0010, 32'd3, 3);
    wait_done("t1", 40);
    check("t1_xfers", xfer_count, 5);
    check("t1_consecutive", last_cyc - first_cyc, 4);
    check("t1_grant_idle", grant_o, 0);
    check("t1_busy_idle", busy_o, 0);

    // size=0 on ch1: header and size only
    xfer_count = 0;
    load_pkt(1, 32'hB100_0020, 32'd0, 0);
    wait_done("t3", 40);
    check("t3_xfers", xfer_count, 2);

    // Both channels continuously requesting: ch0, ch1, ch0, ch1
    xfer_count = 0;
    load_pkt(0, 32'hC000_0100, 32'd2, 2);
    load_pkt(1, 32'hC100_0200, 32'd2, 2);
    load_pkt(0, 32'hC000_0300, 32'd2, 2);
    load_pkt(1, 32'hC100_0400, 32'd2, 2);
    wait_done("t2", 120);
    check("t2_xfers", xfer_count, 16);

    // Credit low for 4 cycles mid-payload
    xfer_count = 0;
    load_pkt(0, 32'hD400_0040, 32'd3, 3);
    wait_xfers("t4_start", 3, 40);
    noc_credit_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) held = noc_data_o;
      check("t4_tx_held", noc_tx_o, 1);
      check("t4_data_stable", noc_data_o, 32'hD400_0042);
      check("t4_busy", busy_o, 1);
    end
    check("t4_first_held", held, 32'hD400_0042);
    step();
    noc_credit_i = 1'b1;
    wait_done("t4", 40);
    check("t4_xfers", xfer_count, 5);

    // Oversized size flit is clamped to MAX_PAYLOAD payloads
    xfer_count = 0;
    load_pkt(1, 32'hE100_0050, 32'd9, 6);
    wait_done("t5", 60);
    check("t5_xfers", xfer_count, 8);

    // Granted source stalls mid-packet; ch1 waits, no interleave
    xfer_count = 0;
    load_pkt(0, 32'hF000_0060, 32'd3, 3);
    load_pkt(1, 32'hF100_0070, 32'd1, 1);
    wait_xfers("t6_start", 3, 40);
    hold = 2'b01;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_grant_held", grant_o, 2'b01);
      check("t6_no_interleave", noc_tx_o, 0);
      check("t6_busy", busy_o, 1);
    end
    step();
    hold = 2'b00;
    wait_done("t6", 60);
    check("t6_xfers", xfer_count, 8);

    // release_i dropped after header: ch0 completes, ch1 stays ungranted
    xfer_count = 0;
    load_pkt(0, 32'h7000_0080, 32'd4, 4);
    load_pkt(1, 32'h7100_0090, 32'd1, 1);
    wait_xfers("t7_start", 1, 40);
    release_i = 1'b0;
    c = 0;
    while (busy_o && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (busy_o) fail_now("t7_complete", "packet did not finish with release low");
    check("t7_ch0_xfers", xfer_count, 6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t7_no_grant", grant_o, 0);
      check("t7_not_busy", busy_o, 0);
      check("t7_no_tx", noc_tx_o, 0);
    end
    step();
    release_i = 1'b1;
    wait_done("t7", 40);
    check("t7_xfers", xfer_count, 9);

    // Reset during payload drops the packet; ch0 wins afterwards
    xfer_count = 0;
    load_pkt(0, 32'h9000_00A0, 32'd4, 4);
    wait_xfers("t8_start", 3, 40);
    rst_i = 1'b1;
    exp_q.delete();
    q0.delete();
    q1.delete();
    @(negedge clk);
    check("t8_rst_tx", noc_tx_o, 0);
    check("t8_rst_credit", src_credit_o, 0);
    step();
    check("t8_rst_grant", grant_o, 0);
    check("t8_rst_busy", busy_o, 0);
    load_pkt(0, 32'h9000_00B0, 32'd1, 1);
    load_pkt(1, 32'h9100_00C0, 32'd1, 1);
    step();
    rst_i = 1'b0;
    xfer_count = 0;
    wait_done("t8", 60);
    check("t8_xfers", xfer_count, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
